// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: bus-facing UART buffer block.
// A TX FIFO feeds a small launcher FSM that hands bytes to a serial
// transmitter. An RX FIFO collects bytes from a serial receiver and is
// drained through the DATA register. A STATUS register reports FIFO state
// and a sticky overrun flag. Every register uses a synchronous, active-high
// reset.

module uart_fifo_ctrl #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       addr,
   input  logic       wr_en,
   input  logic       rd_en,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       tx_start,
   output logic [7:0] tx_data,
   input  logic       tx_busy,
   input  logic       rx_ready,
   input  logic [7:0] rx_data,
   output logic       tx_full,
   output logic       rx_empty,
   output logic       rx_overrun
);

   localparam int Depth = 1 << DEPTH_LOG2;

   typedef logic [DEPTH_LOG2-1:0] ptr_t;
   typedef logic [DEPTH_LOG2:0]   cnt_t;

   localparam cnt_t FullCount = cnt_t'(Depth);
   localparam cnt_t OneCount  = cnt_t'(1);
   localparam ptr_t OnePtr    = ptr_t'(1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2
   } tx_state_t;

   // ------------------------------------------------------------------
   // TX side storage and state
   // ------------------------------------------------------------------
   logic [7:0] txMem [Depth];
   ptr_t       txWrPtr_q, txWrPtr_d;
   ptr_t       txRdPtr_q, txRdPtr_d;
   cnt_t       txCount_q, txCount_d;
   tx_state_t  txState_q;
   logic       txStart_q;
   logic [7:0] txData_q;

   logic       txEmpty;
   logic       txIdle;
   logic       txLaunch;
   logic       txPush;

   // ------------------------------------------------------------------
   // RX side storage and state
   // ------------------------------------------------------------------
   logic [7:0] rxMem [Depth];
   ptr_t       rxWrPtr_q, rxWrPtr_d;
   ptr_t       rxRdPtr_q, rxRdPtr_d;
   cnt_t       rxCount_q, rxCount_d;
   logic       rxOverrun_q, rxOverrun_d;
   logic       rxFull;

   logic       rxPop;
   logic       rxPush;
   logic       overrunSet;
   logic       overrunClear;

   logic [7:0] rdata_q, rdata_d;
   logic [7:0] statusWord;

   assign txEmpty  = (txCount_q == '0);
   assign tx_full  = (txCount_q == FullCount);
   assign rxFull   = (rxCount_q == FullCount);
   assign rx_empty = (rxCount_q == '0);

   // A launch happens only from IDLE with the transmitter seen free, so a
   // busy transmitter left over from before a reset is never interrupted.
   assign txLaunch = (txState_q == IDLE) && !txEmpty && !tx_busy;

   // A full TX FIFO still accepts a write in the same cycle that a launch
   // frees the head slot.
   assign txPush   = wr_en && !addr && (!tx_full || txLaunch);
   assign txIdle   = txEmpty && (txState_q == IDLE);

   assign rxPop        = rd_en && !addr && !rx_empty;
   assign rxPush       = rx_ready && (!rxFull || rxPop);
   assign overrunSet   = rx_ready && rxFull && !rxPop;
   assign overrunClear = wr_en && addr && wdata[0];

   assign statusWord = {4'b0000, txIdle, rxOverrun_q, ~rx_empty, ~tx_full};

   assign rdata      = rdata_q;
   assign tx_start   = txStart_q;
   assign tx_data    = txData_q;
   assign rx_overrun = rxOverrun_q;

   // Next-state for the TX FIFO pointers and occupancy count.
   always_comb begin
      txWrPtr_d = txWrPtr_q;
      txRdPtr_d = txRdPtr_q;
      txCount_d = txCount_q;
      if (txPush) begin
         txWrPtr_d = txWrPtr_q + OnePtr;
      end
      if (txLaunch) begin
         txRdPtr_d = txRdPtr_q + OnePtr;
      end
      case ({txPush, txLaunch})
         2'b10:   txCount_d = txCount_q + OneCount;
         2'b01:   txCount_d = txCount_q - OneCount;
         default: txCount_d = txCount_q;
      endcase
   end

   // Next-state for the RX FIFO pointers, count and sticky overrun flag.
   always_comb begin
      rxWrPtr_d   = rxWrPtr_q;
      rxRdPtr_d   = rxRdPtr_q;
      rxCount_d   = rxCount_q;
      rxOverrun_d = rxOverrun_q;
      if (rxPush) begin
         rxWrPtr_d = rxWrPtr_q + OnePtr;
      end
      if (rxPop) begin
         rxRdPtr_d = rxRdPtr_q + OnePtr;
      end
      case ({rxPush, rxPop})
         2'b10:   rxCount_d = rxCount_q + OneCount;
         2'b01:   rxCount_d = rxCount_q - OneCount;
         default: rxCount_d = rxCount_q;
      endcase
      // A new overrun outranks a clear arriving in the same cycle.
      if (overrunSet) begin
         rxOverrun_d = 1'b1;
      end else if (overrunClear) begin
         rxOverrun_d = 1'b0;
      end
   end

   // Next value of the read-data register; it holds when no read is made.
   always_comb begin
      rdata_d = rdata_q;
      if (rd_en) begin
         if (addr) begin
            rdata_d = statusWord;
         end else if (rx_empty) begin
            rdata_d = 8'h00;
         end else begin
            rdata_d = rxMem[rxRdPtr_q];
         end
      end
   end

   // FIFO storage arrays; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (txPush) begin
         txMem[txWrPtr_q] <= wdata;
      end
      if (rxPush) begin
         rxMem[rxWrPtr_q] <= rx_data;
      end
   end

   // Pointer, count, flag and read-data registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         txWrPtr_q   <= '0;
         txRdPtr_q   <= '0;
         txCount_q   <= '0;
         rxWrPtr_q   <= '0;
         rxRdPtr_q   <= '0;
         rxCount_q   <= '0;
         rxOverrun_q <= 1'b0;
         rdata_q     <= 8'h00;
      end else begin
         txWrPtr_q   <= txWrPtr_d;
         txRdPtr_q   <= txRdPtr_d;
         txCount_q   <= txCount_d;
         rxWrPtr_q   <= rxWrPtr_d;
         rxRdPtr_q   <= rxRdPtr_d;
         rxCount_q   <= rxCount_d;
         rxOverrun_q <= rxOverrun_d;
         rdata_q     <= rdata_d;
      end
   end

   // TX launcher: pulse tx_start with the FIFO head, then follow tx_busy up and down.
   always_ff @(posedge clk) begin
      if (rst) begin
         txState_q <= IDLE;
         txStart_q <= 1'b0;
         txData_q  <= 8'h00;
      end else begin
         txStart_q <= 1'b0;
         case (txState_q)
            IDLE: begin
               if (txLaunch) begin
                  txStart_q <= 1'b1;
                  txData_q  <= txMem[txRdPtr_q];
                  txState_q <= WAIT_BUSY;
               end
            end
            WAIT_BUSY: begin
               if (tx_busy) begin
                  txState_q <= WAIT_DONE;
               end
            end
            WAIT_DONE: begin
               if (!tx_busy) begin
                  txState_q <= IDLE;
               end
            end
            default: begin
               txState_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb_uart_fifo_ctrl: scoreboard bench for uart_fifo_ctrl.
// Expected TX bytes and RX bytes are queued as stimulus is driven. A
// transmitter model answers each tx_start with a busy window and checks
// each pulse against the TX queue. Bus reads are checked against the RX
// queue, which also serves as the bench's own model of RX occupancy.

module tb_uart_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       addr;
   logic       wr_en;
   logic       rd_en;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_busy;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       tx_full;
   logic       rx_empty;
   logic       rx_overrun;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] txExpQ [$];
   logic [7:0] rxExpQ [$];

   int         txPulses  = 0;
   int         busyTimer = 0;
   int         busyLen   = 4;
   bit         holdBusy  = 1'b0;
   logic [7:0] monExp;

   uart_fifo_ctrl #(.DEPTH_LOG2(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .addr       (addr),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .wdata      (wdata),
      .rdata      (rdata),
      .tx_start   (tx_start),
      .tx_data    (tx_data),
      .tx_busy    (tx_busy),
      .rx_ready   (rx_ready),
      .rx_data    (rx_data),
      .tx_full    (tx_full),
      .rx_empty   (rx_empty),
      .rx_overrun (rx_overrun)
   );

   always #5 clk = ~clk;

   // Transmitter model: check every tx_start pulse, then report busy for a while.
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start === 1'b1) begin
            txPulses++;
            vectors++;
            if (txExpQ.size() == 0) begin
               miscompares++;
               $display("[TB] FAIL tx_unexpected: got tx_start with tx_data=%02h, required no pulse", tx_data);
            end else begin
               monExp = txExpQ.pop_front();
               if (tx_data !== monExp) begin
                  miscompares++;
                  $display("[TB] FAIL tx_byte: got %02h, required %02h", tx_data, monExp);
               end
            end
            vectors++;
            if (tx_busy !== 1'b0) begin
               miscompares++;
               $display("[TB] FAIL tx_start_while_busy: tx_busy was %b at launch, required 0", tx_busy);
            end
            busyTimer = busyLen;
         end
         tx_busy = holdBusy || (busyTimer > 0);
         if (busyTimer > 0) begin
            busyTimer--;
         end
      end
   end

   // Watchdog so the bench always terminates.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic busWrite(input logic a, input logic [7:0] d);
      addr  = a;
      wdata = d;
      wr_en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic busRead(input logic a, output logic [7:0] r);
      addr  = a;
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      r = rdata;
   endtask

   task automatic rxPulse(input logic [7:0] d);
      rx_data  = d;
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      rx_data  = 8'h00;
   endtask

   task automatic waitTxDrain(input int limit);
      int n = 0;
      while (txExpQ.size() != 0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (txExpQ.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL tx_drain_timeout: %0d bytes still expected, required 0", txExpQ.size());
         txExpQ.delete();
      end
      repeat (30) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      addr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wdata = 8'h00;
      rx_ready = 1'b0; rx_data = 8'h00;
      repeat (3) @(negedge clk);
      vectors++;
      if (tx_start !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tx_start: got %b, required 0", tx_start); end
      vectors++;
      if (tx_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_tx_data: got %02h, required 00", tx_data); end
      vectors++;
      if (rdata !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_rdata: got %02h, required 00", rdata); end
      vectors++;
      if (rx_overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overrun: got %b, required 0", rx_overrun); end
      vectors++;
      if (tx_full !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tx_full: got %b, required 0", tx_full); end
      vectors++;
      if (rx_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_rx_empty: got %b, required 1", rx_empty); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_tx_basic();
      logic [7:0] r;
      txExpQ.push_back(8'h41);
      busWrite(1'b0, 8'h41);
      txExpQ.push_back(8'h42);
      busWrite(1'b0, 8'h42);
      waitTxDrain(200);
      busRead(1'b1, r);
      vectors++;
      if (r !== 8'h09) begin miscompares++; $display("[TB] FAIL tx_basic_status: got %02h, required 09", r); end
   endtask

   task automatic test_tx_full();
      logic [7:0] r;
      int base = txPulses;
      int n = 0;
      txExpQ.push_back(8'h10);
      busWrite(1'b0, 8'h10);
      while (txPulses == base && n < 20) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (txPulses == base) begin miscompares++; $display("[TB] FAIL tx_first_launch: got no pulse, required one"); end
      holdBusy = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         txExpQ.push_back(8'h10 + 8'(i));
         busWrite(1'b0, 8'h10 + 8'(i));
      end
      vectors++;
      if (tx_full !== 1'b1) begin miscompares++; $display("[TB] FAIL tx_full_set: got %b, required 1", tx_full); end
      busWrite(1'b0, 8'h21);
      vectors++;
      if (tx_full !== 1'b1) begin miscompares++; $display("[TB] FAIL tx_full_after_drop: got %b, required 1", tx_full); end
      busRead(1'b1, r);
      vectors++;
      if (r !== 8'h00) begin miscompares++; $display("[TB] FAIL tx_full_status: got %02h, required 00", r); end
      holdBusy = 1'b0;
      waitTxDrain(600);
      vectors++;
      if (txPulses - base != 17) begin miscompares++; $display("[TB] FAIL tx_pulse_total: got %0d, required 17", txPulses - base); end
   endtask

   task automatic test_rx_basic();
      logic [7:0] r;
      logic [7:0] e;
      rxExpQ.push_back(8'h55);
      rxPulse(8'h55);
      rxExpQ.push_back(8'hAA);
      rxPulse(8'hAA);
      // First read overlaps a TX DATA write; both must take effect.
      txExpQ.push_back(8'h77);
      addr  = 1'b0;
      wdata = 8'h77;
      wr_en = 1'b1;
      rd_en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
      rd_en = 1'b0;
      e = rxExpQ.pop_front();
      vectors++;
      if (rdata !== e) begin miscompares++; $display("[TB] FAIL rx_read_1: got %02h, required %02h", rdata, e); end
      busRead(1'b0, r);
      e = (rxExpQ.size() != 0) ? rxExpQ.pop_front() : 8'h00;
      vectors++;
      if (r !== e) begin miscompares++; $display("[TB] FAIL rx_read_2: got %02h, required %02h", r, e); end
      vectors++;
      if (rx_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL rx_empty_after_reads: got %b, required 1", rx_empty); end
      busRead(1'b0, r);
      vectors++;
      if (r !== 8'h00) begin miscompares++; $display("[TB] FAIL rx_read_empty: got %02h, required 00", r); end
      waitTxDrain(200);
   endtask

   task automatic test_rx_overrun();
      logic [7:0] r;
      logic [7:0] e;
      for (int i = 0; i < 17; i++) begin
         if (rxExpQ.size() < 16) rxExpQ.push_back(8'h80 + 8'(i));
         rxPulse(8'h80 + 8'(i));
      end
      vectors++;
      if (rx_overrun !== 1'b1) begin miscompares++; $display("[TB] FAIL overrun_set: got %b, required 1", rx_overrun); end
      busWrite(1'b1, 8'hFE);
      vectors++;
      if (rx_overrun !== 1'b1) begin miscompares++; $display("[TB] FAIL overrun_bit0_only: got %b, required 1", rx_overrun); end
      for (int i = 0; i < 16; i++) begin
         busRead(1'b0, r);
         e = (rxExpQ.size() != 0) ? rxExpQ.pop_front() : 8'h00;
         vectors++;
         if (r !== e) begin miscompares++; $display("[TB] FAIL overrun_read_%0d: got %02h, required %02h", i, r, e); end
      end
      vectors++;
      if (rx_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL overrun_drained: got %b, required 1", rx_empty); end
      busWrite(1'b1, 8'h01);
      vectors++;
      if (rx_overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL overrun_clear: got %b, required 0", rx_overrun); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] r;
      logic [7:0] e;
      for (int i = 0; i < 16; i++) begin
         rxExpQ.push_back(8'hC0 + 8'(i));
         rxPulse(8'hC0 + 8'(i));
      end
      // Receive into a full FIFO in the same cycle as a DATA read.
      addr     = 1'b0;
      rd_en    = 1'b1;
      rx_ready = 1'b1;
      rx_data  = 8'h99;
      @(negedge clk);
      rd_en    = 1'b0;
      rx_ready = 1'b0;
      rx_data  = 8'h00;
      e = rxExpQ.pop_front();
      rxExpQ.push_back(8'h99);
      vectors++;
      if (rdata !== e) begin miscompares++; $display("[TB] FAIL b2b_read: got %02h, required %02h", rdata, e); end
      vectors++;
      if (rx_overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_no_overrun: got %b, required 0", rx_overrun); end
      for (int i = 0; i < 16; i++) begin
         busRead(1'b0, r);
         e = (rxExpQ.size() != 0) ? rxExpQ.pop_front() : 8'h00;
         vectors++;
         if (r !== e) begin miscompares++; $display("[TB] FAIL b2b_drain_%0d: got %02h, required %02h", i, r, e); end
      end
      vectors++;
      if (r !== 8'h99) begin miscompares++; $display("[TB] FAIL b2b_last_byte: got %02h, required 99", r); end
      busRead(1'b0, r);
      vectors++;
      if (r !== 8'h00) begin miscompares++; $display("[TB] FAIL b2b_count_16: got %02h, required 00", r); end

      // Overrun set coinciding with a STATUS clear write: the set wins.
      for (int i = 0; i < 16; i++) begin
         rxExpQ.push_back(8'hD0 + 8'(i));
         rxPulse(8'hD0 + 8'(i));
      end
      addr     = 1'b1;
      wdata    = 8'h01;
      wr_en    = 1'b1;
      rx_ready = 1'b1;
      rx_data  = 8'hEE;
      @(negedge clk);
      wr_en    = 1'b0;
      rx_ready = 1'b0;
      rx_data  = 8'h00;
      vectors++;
      if (rx_overrun !== 1'b1) begin miscompares++; $display("[TB] FAIL set_beats_clear: got %b, required 1", rx_overrun); end
      for (int i = 0; i < 16; i++) begin
         busRead(1'b0, r);
         e = (rxExpQ.size() != 0) ? rxExpQ.pop_front() : 8'h00;
         vectors++;
         if (r !== e) begin miscompares++; $display("[TB] FAIL set_win_drain_%0d: got %02h, required %02h", i, r, e); end
      end
      busWrite(1'b1, 8'h01);
      vectors++;
      if (rx_overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL set_win_clear: got %b, required 0", rx_overrun); end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] r;
      int base = txPulses;
      busyLen = 20;
      txExpQ.push_back(8'h61);
      busWrite(1'b0, 8'h61);
      busWrite(1'b0, 8'h62);
      busWrite(1'b0, 8'h63);
      busWrite(1'b0, 8'h64);
      repeat (2) @(negedge clk);
      busRead(1'b1, r);
      vectors++;
      if (r !== 8'h01) begin miscompares++; $display("[TB] FAIL midframe_status: got %02h, required 01", r); end
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if (tx_start !== 1'b0) begin miscompares++; $display("[TB] FAIL midframe_tx_start: got %b, required 0", tx_start); end
      vectors++;
      if (tx_data !== 8'h00) begin miscompares++; $display("[TB] FAIL midframe_tx_data: got %02h, required 00", tx_data); end
      vectors++;
      if (rdata !== 8'h00) begin miscompares++; $display("[TB] FAIL midframe_rdata: got %02h, required 00", rdata); end
      vectors++;
      if (rx_overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL midframe_overrun: got %b, required 0", rx_overrun); end
      vectors++;
      if (tx_full !== 1'b0) begin miscompares++; $display("[TB] FAIL midframe_tx_full: got %b, required 0", tx_full); end
      vectors++;
      if (rx_empty !== 1'b1) begin miscompares++; $display("[TB] FAIL midframe_rx_empty: got %b, required 1", rx_empty); end
      rst = 1'b0;
      repeat (40) @(negedge clk);
      vectors++;
      if (txPulses - base != 1) begin miscompares++; $display("[TB] FAIL midframe_pulses: got %0d, required 1", txPulses - base); end
      busRead(1'b1, r);
      vectors++;
      if (r !== 8'h09) begin miscompares++; $display("[TB] FAIL midframe_status_after: got %02h, required 09", r); end
      busyLen = 4;
   endtask

   // Run every scenario in order, then report.
   initial begin
      test_reset();
      test_tx_basic();
      test_tx_full();
      test_rx_basic();
      test_rx_overrun();
      test_back_to_back();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
